hs_arith_multi_out_usplitter: RTL and testbench
===============================================

// Module: hs_arith_multi_out_usplitter
// PURPOSE
//  Sequential inverse of the multi-input unsigned adder. Accepts one unsigned
//  total and splits it into OUTPUT_NUM words of DATA_WIDTH bits. The words are
//  emitted one per handshake and sum to the total (saturated at OUTPUT_MAX).
//  Sits in front of per-lane consumers (credit/token distribution).
//  Word k = min(remaining, EACH_OUTPUT_MAX): a greedy, lane-0-first fill.
// PARAMETERS
//  DATA_WIDTH       4   width of each emitted word (1-4096)
//  OUTPUT_NUM       4   number of words emitted per total (2-128)
//  EACH_OUTPUT_MAX  -   local: 2**DATA_WIDTH - 1
//  OUTPUT_MAX       -   local: OUTPUT_NUM * EACH_OUTPUT_MAX
//  TOTAL_WIDTH      -   local: $clog2(OUTPUT_MAX + 1)
//  INDEX_WIDTH      -   local: $clog2(OUTPUT_NUM)
// PORTS
//  clk        in   1            clock, rising edge
//  rst_n      in   1            asynchronous active-low reset
//  in_valid   in   1            in_total valid
//  in_ready   out  1            block can accept a total
//  in_total   in   TOTAL_WIDTH  unsigned value to split
//  out_valid  out  1            out_data/out_index/out_last/out_ovf valid
//  out_ready  in   1            consumer accepts current word
//  out_data   out  DATA_WIDTH   current word
//  out_index  out  INDEX_WIDTH  lane index of current word, 0..OUTPUT_NUM-1
//  out_last   out  1            current word is lane OUTPUT_NUM-1
//  out_ovf    out  1            in_total exceeded OUTPUT_MAX; held for the whole burst
// BEHAVIOUR
//  - FSM with two states: IDLE and EMIT. Reset state is IDLE.
//  - Reset values: in_ready=1, out_valid=0, out_data=0, out_index=0,
//    out_last=0, out_ovf=0. Reset is async assert, sync deassert externally.
//  - IDLE: in_ready=1, out_valid=0. On (in_valid & in_ready):
//      rem <= min(in_total, OUTPUT_MAX); ovf <= (in_total > OUTPUT_MAX);
//      idx <= 0; go to EMIT.
//  - EMIT: in_ready=0, out_valid=1. This state ignores in_valid.
//      out_data = min(rem, EACH_OUTPUT_MAX); out_index = idx;
//      out_last = (idx == OUTPUT_NUM-1).
//  - On (out_valid & out_ready): rem <= rem - out_data; idx <= idx + 1.
//    If out_last, return to IDLE.
//  - Latency: a total accepted at edge N gives first out_valid after edge N.
//    With out_ready=1, the burst is exactly OUTPUT_NUM cycles. One IDLE cycle
//    separates bursts. in_ready has no combinational path from out_ready.
//  - Exactly OUTPUT_NUM words are emitted per total. Trailing words may be 0.
//  - Stall: while out_valid & !out_ready, all out_* are held stable.
//  - Arithmetic: rem is TOTAL_WIDTH bits and never underflows.
//    The sum of the burst equals min(in_total, OUTPUT_MAX).
//  - Reset mid-burst: out_valid drops to 0 immediately (async) and the burst
//    is discarded. After release the block is in IDLE with in_ready=1.
//  - Outputs are registered. out_data is a function of registered rem only.
// TESTING (DATA_WIDTH=4, OUTPUT_NUM=4: EACH_MAX=15, OUTPUT_MAX=60, TOTAL_WIDTH=6)
//  1. in_total=37, out_ready=1 -> words 15,15,7,0; idx 0..3; out_last only at
//     idx 3; out_ovf=0; in_ready=1 the cycle after the last word.
//  2. in_total=63 -> words 15,15,15,15 with out_ovf=1 on all four words.
//  3. in_total=0 -> words 0,0,0,0, with out_valid still asserted for 4 handshakes.
//  4. in_total=20, out_ready=0 for 3 cycles after the first out_valid ->
//     out_data=15, idx=0 held for those cycles. A second in_valid raised
//     during EMIT is not accepted (in_ready=0). Then words 15,5,0,0.
//  5. in_total=45, rst_n low after 2 handshakes -> out_valid=0 the same cycle.
//     After release in_ready=1; in_total=5 -> words 5,0,0,0, out_ovf=0.
//  6. Back-to-back in_valid with totals 60 then 16 -> 15,15,15,15, then one
//     idle cycle, then 15,1,0,0. Each burst's sum is checked against its total.

Source files
------------

// File: rtl/hs_arith_multi_out_usplitter.sv
// Splits one unsigned total into OUTPUT_NUM words, one per output handshake.
// Greedy lane-0-first fill: word k = min(remaining, EACH_OUTPUT_MAX), totals above OUTPUT_MAX saturate.
module hs_arith_multi_out_usplitter #(
  parameter  int DATA_WIDTH  = 4,
  parameter  int OUTPUT_NUM  = 4,
  localparam int OUTPUT_NUM_W = $clog2(OUTPUT_NUM + 1),
  localparam int MAX_W        = DATA_WIDTH + OUTPUT_NUM_W,
  localparam logic [DATA_WIDTH-1:0] EACH_OUTPUT_MAX = '1,
  localparam logic [MAX_W-1:0] OUTPUT_MAX = MAX_W'(OUTPUT_NUM) * MAX_W'(EACH_OUTPUT_MAX),
  localparam int TOTAL_WIDTH = $clog2({1'b0, OUTPUT_MAX} + 1'b1),
  localparam int INDEX_WIDTH = $clog2(OUTPUT_NUM)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [TOTAL_WIDTH-1:0] in_total,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic [INDEX_WIDTH-1:0] out_index,
  output logic                   out_last,
  output logic                   out_ovf
);

  localparam logic [TOTAL_WIDTH-1:0] OUTPUT_MAX_T = OUTPUT_MAX[TOTAL_WIDTH-1:0];
  localparam logic [TOTAL_WIDTH-1:0] EACH_MAX_T   = TOTAL_WIDTH'(EACH_OUTPUT_MAX);
  localparam logic [INDEX_WIDTH-1:0] LAST_IDX     = INDEX_WIDTH'(OUTPUT_NUM - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_EMIT = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [TOTAL_WIDTH-1:0] rem_q, rem_d;
  logic [INDEX_WIDTH-1:0] idx_q, idx_d;
  logic                   ovf_q, ovf_d;
  logic                   in_fire;
  logic                   out_fire;
  logic                   at_last;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign at_last  = (idx_q == LAST_IDX);

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (in_fire) state_d = S_EMIT;
      S_EMIT: if (out_fire && at_last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode registered state only, so in_ready has no path from out_ready.
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_EMIT);
    out_data  = (rem_q > EACH_MAX_T) ? EACH_OUTPUT_MAX : rem_q[DATA_WIDTH-1:0];
    out_index = idx_q;
    out_last  = (state_q == S_EMIT) && at_last;
    out_ovf   = ovf_q;
  end

  // Datapath: load on acceptance, drain one word per output handshake.
  always_comb begin
    rem_d = rem_q;
    idx_d = idx_q;
    ovf_d = ovf_q;
    if (in_fire) begin
      rem_d = (in_total > OUTPUT_MAX_T) ? OUTPUT_MAX_T : in_total;
      ovf_d = (in_total > OUTPUT_MAX_T);
      idx_d = '0;
    end else if (out_fire) begin
      // out_data never exceeds rem_q, so this subtraction cannot underflow.
      rem_d = rem_q - TOTAL_WIDTH'(out_data);
      idx_d = at_last ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      idx_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      rem_q <= rem_d;
      idx_q <= idx_d;
      ovf_q <= ovf_d;
    end
  end

endmodule

// File: tb/tb_hs_arith_multi_out_usplitter.sv
// Directed bench for hs_arith_multi_out_usplitter at DATA_WIDTH=4, OUTPUT_NUM=4.
// Inputs change and outputs are sampled on the falling edge; the DUT acts on the rising edge.
module tb_hs_arith_multi_out_usplitter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] in_total;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic [1:0] out_index;
  logic       out_last;
  logic       out_ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hs_arith_multi_out_usplitter #(
    .DATA_WIDTH(4),
    .OUTPUT_NUM(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_total (in_total),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_index(out_index),
    .out_last (out_last),
    .out_ovf  (out_ovf)
  );

  // Checks the four words of a burst that is already running, starting at the current falling edge.
  task automatic check_words(input string name, input int w0, input int w1, input int w2,
                             input int w3, input logic exp_ovf, input int exp_sum);
    int exp_w[4];
    int sum;
    exp_w = '{w0, w1, w2, w3};
    sum = 0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== exp_w[k][3:0] ||
          out_index !== 2'(k) || out_last !== (k == 3) || out_ovf !== exp_ovf) begin
        errors++;
        $display("FAIL %s word%0d: got valid=%b ready=%b data=%0d idx=%0d last=%b ovf=%b want valid=1 ready=0 data=%0d idx=%0d last=%b ovf=%b",
                 name, k, out_valid, in_ready, out_data, out_index, out_last, out_ovf,
                 exp_w[k], k, (k == 3), exp_ovf);
      end
      sum += int'(out_data);
    end
    checks++;
    if (sum !== exp_sum) begin
      errors++;
      $display("FAIL %s burst_sum: got %0d want %0d", name, sum, exp_sum);
    end
  endtask

  // Full burst: accept a total, check the words, then check the idle cycle that follows.
  task automatic run_burst(input string name, input int total, input int w0, input int w1,
                           input int w2, input int w3, input logic exp_ovf);
    int exp_sum;
    exp_sum = (total > 60) ? 60 : total;
    @(negedge clk);
    in_valid = 1'b1;
    in_total = total[5:0];
    out_ready = 1'b1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s accept: got in_ready=%b out_valid=%b want 1 0", name, in_ready, out_valid);
    end
    @(negedge clk);
    in_valid = 1'b0;
    check_words(name, w0, w1, w2, w3, exp_ovf, exp_sum);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s after_burst: got in_ready=%b out_valid=%b want 1 0", name, in_ready, out_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_total = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 4'd0 ||
        out_index !== 2'd0 || out_last !== 1'b0 || out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: got ready=%b valid=%b data=%0d idx=%0d last=%b ovf=%b want 1 0 0 0 0 0",
               in_ready, out_valid, out_data, out_index, out_last, out_ovf);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_split();
    run_burst("split_37", 37, 15, 15, 7, 0, 1'b0);
  endtask

  task automatic test_overflow();
    run_burst("ovf_63", 63, 15, 15, 15, 15, 1'b1);
  endtask

  task automatic test_zero();
    run_burst("zero", 0, 0, 0, 0, 0, 1'b0);
  endtask

  task automatic test_stall();
    @(negedge clk);
    in_valid = 1'b1;
    in_total = 6'd20;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall accept: got in_ready=%b want 1", in_ready);
    end
    @(negedge clk);
    in_total = 6'd50;
    for (int s = 0; s < 3; s++) begin
      if (s > 0) @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== 4'd15 ||
          out_index !== 2'd0 || out_last !== 1'b0 || out_ovf !== 1'b0) begin
        errors++;
        $display("FAIL stall hold%0d: got valid=%b ready=%b data=%0d idx=%0d last=%b ovf=%b want 1 0 15 0 0 0",
                 s, out_valid, in_ready, out_data, out_index, out_last, out_ovf);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b0;
    check_words("stall_20", 15, 5, 0, 0, 1'b0, 20);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall after_burst: got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall no_second_accept: got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_reset_mid_burst();
    @(negedge clk);
    in_valid = 1'b1;
    in_total = 6'd45;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 4'd15 || out_index !== 2'(k)) begin
        errors++;
        $display("FAIL rst_mid word%0d: got valid=%b data=%0d idx=%0d want 1 15 %0d",
                 k, out_valid, out_data, out_index, k);
      end
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_index !== 2'd0 || out_data !== 4'd0) begin
      errors++;
      $display("FAIL rst_mid async_drop: got valid=%b ready=%b idx=%0d data=%0d want 0 1 0 0",
               out_valid, in_ready, out_index, out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_burst("rst_recover_5", 5, 5, 0, 0, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    in_valid = 1'b1;
    in_total = 6'd60;
    out_ready = 1'b1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b accept1: got in_ready=%b want 1", in_ready);
    end
    @(negedge clk);
    in_total = 6'd16;
    check_words("b2b_60", 15, 15, 15, 15, 1'b0, 60);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b idle_gap: got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    check_words("b2b_16", 15, 1, 0, 0, 1'b0, 16);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b after_burst: got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_split();
    test_overflow();
    test_zero();
    test_stall();
    test_reset_mid_burst();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
